// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: Mode-0 SPI master shared round-robin between NUM_REQ requesters.
// Each requester owns one active-low chip select; transfers run MSB-first, up to MAX_WIDTH bits.
module spi_master_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned MAX_WIDTH = 8,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  input  logic [NUM_REQ*MAX_WIDTH-1:0] req_tx,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [MAX_WIDTH-1:0]         rx_data,
  output logic                         busy,
  output logic                         spi_clk,
  output logic                         spi_mosi,
  input  logic                         spi_miso,
  output logic [NUM_REQ-1:0]           spi_cs_n
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StClkHi,
    StClkLo,
    StHold,
    StGap
  } state_e;

  state_e                 r_state;
  logic [PH_W-1:0]        r_phase;
  logic [PTR_W-1:0]       r_last;
  logic [NUM_REQ-1:0]     r_grant;
  logic [NUM_REQ-1:0]     r_done;
  logic [MAX_WIDTH-1:0]   r_rx_data;
  logic                   r_busy;
  logic                   r_sclk;
  logic                   r_mosi;
  logic [NUM_REQ-1:0]     r_cs_n;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_bits;
  logic [MAX_WIDTH-1:0]   r_tx_sh;
  logic [MAX_WIDTH-1:0]   r_rx_sh;

  logic                   w_found;
  logic [PTR_W-1:0]       w_pick;
  logic [PTR_W-1:0]       w_cand;
  logic [NUM_REQ-1:0]     w_pick_oh;
  logic [LEN_W-1:0]       w_req_len;
  logic [LEN_W-1:0]       w_len_clamp;
  logic [MAX_WIDTH-1:0]   w_tx;
  logic [MAX_WIDTH-1:0]   w_tx_sh;
  logic                   w_ph_end;
  logic [MAX_WIDTH-1:0]   w_rx_next;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = PTR_W'((32'(r_last) + 32'(i) + 32'd1) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Selected requester's length (clamped) and left-justified TX word.
  always_comb begin
    w_pick_oh   = NUM_REQ'(1) << w_pick;
    w_req_len   = req_len[w_pick*LEN_W +: LEN_W];
    w_len_clamp = (w_req_len > LEN_W'(MAX_WIDTH)) ? LEN_W'(MAX_WIDTH) : w_req_len;
    w_tx        = req_tx[w_pick*MAX_WIDTH +: MAX_WIDTH];
    w_tx_sh     = w_tx << (LEN_W'(MAX_WIDTH) - w_len_clamp);
  end

  assign w_ph_end  = (r_phase == PH_W'(CLK_DIV - 1));
  assign w_rx_next = {r_rx_sh[MAX_WIDTH-2:0], spi_miso};

  // Arbitration and bus sequencing FSM; all bus outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_phase   <= '0;
      r_last    <= PTR_W'(NUM_REQ - 1);
      r_grant   <= '0;
      r_done    <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= '1;
      r_len     <= '0;
      r_bits    <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
    end else begin
      r_done  <= '0;
      r_phase <= w_ph_end ? '0 : r_phase + 1'b1;
      case (r_state)
        StIdle: begin
          r_phase <= '0;
          if (w_found) begin
            r_grant <= w_pick_oh;
            r_busy  <= 1'b1;
            r_last  <= w_pick;
            r_len   <= w_len_clamp;
            r_tx_sh <= w_tx_sh;
            r_rx_sh <= '0;
            r_bits  <= '0;
            if (w_len_clamp == '0) begin
              // Empty transfer: skip the bus entirely and complete immediately.
              r_state   <= StGap;
              r_done    <= w_pick_oh;
              r_rx_data <= '0;
            end else begin
              r_state <= StSetup;
              r_cs_n  <= ~w_pick_oh;
              r_mosi  <= w_tx_sh[MAX_WIDTH-1];
            end
          end
        end
        StSetup: begin
          if (w_ph_end) begin
            r_state <= StClkHi;
            r_sclk  <= 1'b1;
            r_rx_sh <= w_rx_next;
          end
        end
        StClkHi: begin
          if (w_ph_end) begin
            r_state <= StClkLo;
            r_sclk  <= 1'b0;
            r_tx_sh <= r_tx_sh << 1;
            r_mosi  <= r_tx_sh[MAX_WIDTH-2];
            r_bits  <= r_bits + 1'b1;
          end
        end
        StClkLo: begin
          if (w_ph_end) begin
            if (r_bits == r_len) begin
              r_state <= StHold;
            end else begin
              r_state <= StClkHi;
              r_sclk  <= 1'b1;
              r_rx_sh <= w_rx_next;
            end
          end
        end
        StHold: begin
          if (w_ph_end) begin
            r_state   <= StGap;
            r_cs_n    <= '1;
            r_mosi    <= 1'b0;
            r_done    <= r_grant;
            // Received bits are already right-aligned with zeros above them.
            r_rx_data <= r_rx_sh;
          end
        end
        StGap: begin
          if (w_ph_end) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign busy     = r_busy;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a Mode-0 SPI slave model.
module tb_spi_master_arbiter;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned MAX_WIDTH = 8;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned CLK_DIV   = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_W-1:0]     req_len;
  logic [NUM_REQ*MAX_WIDTH-1:0] req_tx;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic [MAX_WIDTH-1:0]         rx_data;
  logic                         busy;
  logic                         spi_clk;
  logic                         spi_mosi;
  logic                         spi_miso;
  logic [NUM_REQ-1:0]           spi_cs_n;

  always #5 clk = ~clk;

  spi_master_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_WIDTH(MAX_WIDTH),
    .LEN_W    (LEN_W),
    .CLK_DIV  (CLK_DIV)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_len (req_len),
    .req_tx  (req_tx),
    .grant   (grant),
    .done    (done),
    .rx_data (rx_data),
    .busy    (busy),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: presents bit (len-1-falls) on MISO, shifts on falling spi_clk.
  logic       cs_act;
  logic [7:0] s_word = '0;
  int         s_len  = 0;
  int         f_base = 0;
  int         s_falls = 0;
  int         s_rises = 0;
  logic [7:0] s_cap = '0;
  int         s_rel;
  logic [7:0] s_tmp;

  assign cs_act = ~&spi_cs_n;

  always_comb begin
    s_rel    = s_falls - f_base;
    s_tmp    = '0;
    spi_miso = 1'b0;
    if (cs_act && s_rel >= 0 && s_rel < s_len) begin
      s_tmp    = s_word >> (s_len - 1 - s_rel);
      spi_miso = s_tmp[0];
    end
  end

  always @(negedge spi_clk) s_falls++;

  always @(posedge spi_clk) begin
    s_rises++;
    s_cap = {s_cap[6:0], spi_mosi};
  end

  // Bus monitor: grant order, chip-select overlap, idle gaps between selects, done pulses.
  logic [2:0]         glog[$];
  int                 gaps[$];
  logic [NUM_REQ-1:0] prev_grant = '0;
  int                 overlap_cnt = 0;
  int                 done_total = 0;
  int                 cs_hi_run = 0;
  bit                 seen_low = 1'b0;

  always @(negedge clk) begin
    if (grant != '0 && prev_grant == '0) glog.push_back(grant);
    prev_grant = grant;
    if ($countones(~spi_cs_n) > 1) overlap_cnt++;
    if (done != '0) done_total++;
    if (spi_cs_n == '1) begin
      cs_hi_run++;
    end else begin
      if (cs_hi_run > 0 && seen_low) gaps.push_back(cs_hi_run);
      cs_hi_run = 0;
      seen_low  = 1'b1;
    end
  end

  // One transfer from requester k; drop_at>0 releases req after that many busy cycles.
  task automatic run_xfer(input string tag, input int k, input int len, input logic [7:0] tx,
                          input logic [7:0] sword, input int n_edges, input logic [7:0] exp_rx,
                          input int exp_busy, input int drop_at);
    int                 t;
    int                 busy_cyc;
    int                 done_cnt;
    int                 r0;
    logic [NUM_REQ-1:0] done_seen;
    logic [7:0]         rx_seen;
    logic [NUM_REQ-1:0] cs_acc;
    logic [NUM_REQ-1:0] exp_cs;
    logic [8:0]         m9;
    logic [7:0]         mask;
    m9     = (9'd1 << n_edges) - 9'd1;
    mask   = m9[7:0];
    s_word = sword;
    s_len  = n_edges;
    f_base = s_falls;
    r0     = s_rises;
    req_len[k*LEN_W +: LEN_W]         = LEN_W'(len);
    req_tx[k*MAX_WIDTH +: MAX_WIDTH]  = tx;
    req[k] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 10);
    busy_cyc  = 0;
    done_cnt  = 0;
    done_seen = '0;
    rx_seen   = '0;
    cs_acc    = '1;
    while (busy && t < 300) begin
      busy_cyc++;
      cs_acc &= spi_cs_n;
      if (done != '0) begin
        done_cnt++;
        done_seen = done;
        rx_seen   = rx_data;
        req[k]    = 1'b0;
      end
      if (busy_cyc == drop_at) req[k] = 1'b0;
      @(negedge clk);
      t++;
    end
    req[k] = 1'b0;
    exp_cs = (n_edges > 0) ? ~(NUM_REQ'(1) << k) : '1;
    check_eq({tag, "_finished"}, 32'(busy), 32'd0);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_done_oh"}, 32'(done_seen), 32'(NUM_REQ'(1) << k));
    check_eq({tag, "_rx"}, 32'(rx_seen), 32'(exp_rx));
    check_eq({tag, "_rx_held"}, 32'(rx_data), 32'(exp_rx));
    check_eq({tag, "_edges"}, s_rises - r0, n_edges);
    if (n_edges > 0) check_eq({tag, "_mosi"}, 32'(s_cap & mask), 32'(tx & mask));
    check_eq({tag, "_busy_cyc"}, busy_cyc, exp_busy);
    check_eq({tag, "_cs"}, 32'(cs_acc), 32'(exp_cs));
  endtask

  int t;
  int n0;
  int n1;
  int g1;
  int d0;
  int e0;
  logic [2:0] exp_rot [6];

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_len = '0;
    req_tx  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rx", 32'(rx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sclk", 32'(spi_clk), 32'd0);
    check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
    check_eq("rst_cs", 32'(spi_cs_n), 32'h7);
    rst = 1'b0;
    @(negedge clk);

    // Full byte, 4-bit, empty and over-length transfers.
    run_xfer("a5", 0, 8, 8'hA5, 8'h3C, 8, 8'h3C, 38, 0);
    run_xfer("len4", 1, 4, 8'h0B, 8'h06, 4, 8'h06, 22, 0);
    run_xfer("len0", 2, 0, 8'hFF, 8'h00, 0, 8'h00, 2, 0);
    run_xfer("len12", 2, 12, 8'h5A, 8'h81, 8, 8'h81, 38, 0);

    // Reset during the third high phase aborts without a done pulse.
    d0 = done_total;
    e0 = s_rises;
    req_len[LEN_W-1:0] = LEN_W'(8);
    req_tx[7:0]        = 8'hFF;
    req[0]             = 1'b1;
    t = 0;
    while ((s_rises - e0) < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("abort_third_hi", 32'(spi_clk), 32'd1);
    rst    = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    check_eq("abort_cs", 32'(spi_cs_n), 32'h7);
    check_eq("abort_sclk", 32'(spi_clk), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_no_done", done_total - d0, 0);
    run_xfer("post_rst", 0, 8, 8'h96, 8'h69, 8, 8'h69, 38, 0);

    // Fresh reset, then req0 and req2 together: 0 is served before 2.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = glog.size();
    s_word  = '0;
    s_len   = 2;
    req_len = {LEN_W'(2), LEN_W'(2), LEN_W'(2)};
    req_tx  = '0;
    req     = 3'b101;
    t = 0;
    while (req != '0 && t < 400) begin
      @(negedge clk);
      t++;
      if (done != '0) req = req & ~done;
    end
    check_eq("rr02_served", 32'(req), 32'd0);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("rr02_count", glog.size() - n0, 2);
    check_eq("rr02_first", 32'(glog[n0]), 32'h1);
    check_eq("rr02_second", 32'(glog[n0+1]), 32'h4);

    // All three held: grants rotate 0,1,2,0,1,2 with a 3-cycle select gap.
    n1 = glog.size();
    g1 = gaps.size();
    req = 3'b111;
    t = 0;
    while (glog.size() < n1 + 6 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    req = '0;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("rot_idle", 32'(busy), 32'd0);
    check_eq("rot_count", glog.size() - n1, 6);
    exp_rot = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) begin
      if (n1 + i < glog.size()) check_eq($sformatf("rot_grant%0d", i), 32'(glog[n1+i]),
                                         32'(exp_rot[i]));
    end
    for (int i = 1; i < 6; i++) begin
      if (g1 + i < gaps.size()) check_eq($sformatf("rot_gap%0d", i), gaps[g1+i], 3);
    end
    check_eq("cs_overlap", overlap_cnt, 0);

    // req0 released mid-transfer: transfer still completes, no re-grant.
    n0 = glog.size();
    run_xfer("drop", 0, 8, 8'h3C, 8'hC3, 8, 8'hC3, 38, 10);
    repeat (5) @(negedge clk);
    check_eq("drop_grant", 32'(grant), 32'd0);
    check_eq("drop_busy", 32'(busy), 32'd0);
    check_eq("drop_grants", glog.size() - n0, 1);
    check_eq("cs_overlap_end", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors,
             n_checks);
    $fatal(1);
  end

endmodule
